arm_mc_controller: RTL and testbench

- Multicycle control unit for the ARM datapath; sits directly upstream of the ALU.
- Decodes the latched instruction fields, sequences the datapath through a 10-state FSM, and drives ALUControl into the ALU.
- Consumes the ALU's ALUFlag bus {N,Z,C,V}, holds it in an architectural flags register, and evaluates ARM condition codes to gate all architectural writes.

---
 rtl/arm_mc_controller_if.sv | 33 +++
 rtl/arm_mc_controller.sv | 207 ++++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_controller_if.sv
// Signal bundle between the multicycle ARM controller and its datapath.
// The datapath (master) supplies instruction fields and ALU flags; the controller (slave) returns enables and selects.
interface arm_mc_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlag;

    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlag,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlag,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: 10-state sequencer, ALU decode, NZCV flags register
// and condition-code gating of every architectural write.
module arm_mc_controller #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    arm_mc_controller_if.slave    bus
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] flags;        // {N,Z,C,V}
    logic       cond_ex_r;
    logic       no_write_r;

    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;

    logic [3:0] cmd;
    logic [1:0] alu_control;
    logic       is_cmp;
    logic       is_add_sub;
    logic [1:0] flag_w;
    logic       cond_ex;
    logic       no_write_dec;
    logic       pcs;

    assign cmd = bus.Funct[4:1];

    // Condition evaluation always looks at the registered flags, never at ALUFlag.
    always_comb begin
        cond_ex = 1'b0;
        unique case (bus.Cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
        endcase
    end

    // CMP only suppresses the register write for data-processing encodings.
    assign no_write_dec = (bus.Op == 2'b00) && (cmd == 4'b1010);

    always_comb begin
        alu_control = 2'b00;
        is_cmp      = 1'b0;
        is_add_sub  = 1'b0;
        if (alu_op) begin
            unique case (cmd)
                4'b0100: begin alu_control = 2'b00; is_add_sub = 1'b1; end
                4'b0010: begin alu_control = 2'b01; is_add_sub = 1'b1; end
                4'b0000: alu_control = 2'b10;
                4'b1100: alu_control = 2'b11;
                4'b1010: begin alu_control = 2'b01; is_cmp = 1'b1; end
                default: alu_control = 2'b00;
            endcase
        end
    end

    assign flag_w[1] = alu_op & (bus.Funct[0] | is_cmp);
    assign flag_w[0] = alu_op & ((bus.Funct[0] & is_add_sub) | is_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            flags      <= RESET_FLAGS;
            cond_ex_r  <= 1'b0;
            no_write_r <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state <= state_next;
            if (state == S_DECODE) begin
                cond_ex_r  <= cond_ex;
                no_write_r <= no_write_dec;
            end
            if (cond_ex_r && flag_w[1]) flags[3:2] <= bus.ALUFlag[3:2];
            if (cond_ex_r && flag_w[0]) flags[1:0] <= bus.ALUFlag[1:0];
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_next = state;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        unique case (state)
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                unique case (bus.Op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                state_next = bus.Funct[0] ? S_MEMREAD : S_MEMWR;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b  = 2'b01;
                alu_op     = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign pcs = branch | (reg_w & (bus.Rd == 4'd15));

    // Enables are masked by reset directly so an interrupted instruction cannot write anything.
    assign bus.PCWrite  = ~reset & (next_pc | (pcs & cond_ex_r));
    assign bus.RegWrite = ~reset & reg_w & cond_ex_r & ~no_write_r;
    assign bus.MemWrite = ~reset & mem_w & cond_ex_r;
    assign bus.IRWrite  = ~reset & ir_write;

    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomised and directed bench for arm_mc_controller: an instruction-level model queues
// the expected per-cycle control outputs, and a negedge monitor compares them.
module tb_arm_mc_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;

    arm_mc_controller_if bus();

    arm_mc_controller #(.RESET_FLAGS(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] aluc;
        logic [3:0] flags;
    } obs_t;

    obs_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] m_flags = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ARM condition: even codes test a base predicate, odd codes its inverse.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            4'b1010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic obs_t mk(input logic pcw, input logic memw, input logic regw,
                                input logic irw, input logic adr, input logic [1:0] srca,
                                input logic [1:0] srcb, input logic [1:0] res,
                                input logic [1:0] aluc, input logic [1:0] op,
                                input logic [3:0] flags);
        obs_t o;
        o.pcw    = pcw;
        o.memw   = memw;
        o.regw   = regw;
        o.irw    = irw;
        o.adr    = adr;
        o.regsrc = {op == 2'b01, op == 2'b10};
        o.srca   = srca;
        o.srcb   = srcb;
        o.res    = res;
        o.imm    = op;
        o.aluc   = aluc;
        o.flags  = flags;
        return o;
    endfunction

    // Called one time unit after the edge that starts a FETCH cycle; returns at the same point for the next one.
    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] aluflag);
        logic pass, is_cmp, s, addsub;
        logic [3:0] cmd;
        int n;
        bus.Cond    = cond;
        bus.Op      = op;
        bus.Funct   = funct;
        bus.Rd      = rd;
        bus.ALUFlag = aluflag;
        pass = cond_holds(cond, m_flags);
        exp_q.push_back(mk(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00, op, m_flags));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, op, m_flags));
        n = 2;
        case (op)
            2'b01: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, op, m_flags));
                if (funct[0]) begin
                    exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, m_flags));
                    exp_q.push_back(mk(pass && rd == 4'd15, 0, pass, 0, 0, 2'b00, 2'b00, 2'b01,
                                       2'b00, op, m_flags));
                    n = 5;
                end else begin
                    exp_q.push_back(mk(0, pass, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, m_flags));
                    n = 4;
                end
            end
            2'b00: begin
                cmd    = funct[4:1];
                s      = funct[0];
                is_cmp = (cmd == 4'b1010);
                addsub = (cmd == 4'b0100) || (cmd == 4'b0010);
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, funct[5] ? 2'b01 : 2'b00, 2'b00,
                                   alu_code(cmd), op, m_flags));
                if (pass && (s || is_cmp))            m_flags[3:2] = aluflag[3:2];
                if (pass && ((s && addsub) || is_cmp)) m_flags[1:0] = aluflag[1:0];
                exp_q.push_back(mk(pass && rd == 4'd15, 0, pass && !is_cmp, 0, 0, 2'b00, 2'b00,
                                   2'b00, 2'b00, op, m_flags));
                n = 4;
            end
            2'b10: begin
                exp_q.push_back(mk(pass, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, op, m_flags));
                n = 3;
            end
            default: n = 2;
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: enables must be dead during reset; otherwise each cycle consumes one expected record.
    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (reset) begin
            check("reset_enables", {28'd0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pcw    = bus.PCWrite;
            a.memw   = bus.MemWrite;
            a.regw   = bus.RegWrite;
            a.irw    = bus.IRWrite;
            a.adr    = bus.AdrSrc;
            a.regsrc = bus.RegSrc;
            a.srca   = bus.ALUSrcA;
            a.srcb   = bus.ALUSrcB;
            a.res    = bus.ResultSrc;
            a.imm    = bus.ImmSrc;
            a.aluc   = bus.ALUControl;
            a.flags  = dut.flags;
            check($sformatf("cycle%0d", cyc), {11'd0, a}, {11'd0, e});
            cyc++;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        bus.Cond    = 4'b1110;
        bus.Op      = 2'b11;
        bus.Funct   = 6'd0;
        bus.Rd      = 4'd0;
        bus.ALUFlag = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ADDS immediate, then CMP with Z set followed by BEQ (taken) and BNE (not taken)
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
        run_instr(4'b1110, 2'b00, 6'b010101, 4'd2, 4'b0100);
        run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b1111);
        run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b1111);

        // LDR, STR, LDR into PC
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd4, 4'b1010);
        run_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b1010);
        run_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);

        // Clear flags, then GT (holds on 0000), EQ (fails), MOV to R15 with AL
        run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0000);
        run_instr(4'b1100, 2'b00, 6'b001001, 4'd5, 4'b1001);
        run_instr(4'b0000, 2'b00, 6'b001001, 4'd5, 4'b0110);
        run_instr(4'b0000, 2'b01, 6'b011000, 4'd5, 4'b0110);
        run_instr(4'b1110, 2'b00, 6'b011010, 4'd15, 4'b0000);

        // Partial flag write: all-ones flags, ANDS keeps C,V; then an Op=11 no-op
        run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b1111);
        run_instr(4'b1110, 2'b00, 6'b000001, 4'd6, 4'b0000);
        run_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b1111);
        run_instr(4'b1011, 2'b00, 6'b011001, 4'd7, 4'b0101);

        for (int i = 0; i < 80; i++) begin
            run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Reset for two cycles while an ANDS sits in EXECR; flags must not pick up ALUFlag
        bus.Cond    = 4'b1110;
        bus.Op      = 2'b00;
        bus.Funct   = 6'b000001;
        bus.Rd      = 4'd3;
        bus.ALUFlag = 4'b1111;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_flags = 4'b0000;
        run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
        run_instr(4'b0110, 2'b10, 6'b000000, 4'd0, 4'b0000);

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
